pll_lock_supervisor: RTL and testbench

Supervises the board rPLL from the 100 MHz reference domain. It drives the PLL RESET input and monitors the asynchronous LOCK output. It enforces a lock-stability window and retries on lock timeout. Downstream resets are released in order (system first, then DSP), and lock-loss and retry events are counted for the status registers.

---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/lock_sync.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 132 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    REL_SYS,
    RUN
  } state_t;

  // Bits needed for a counter that runs 0 .. max(cycle params)-1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: retries on lock timeout, qualifies lock stability,
// releases system then DSP resets, and counts lock losses and retries.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 100000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned SEQ_GAP_CYC      = 64,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             clr_stat,
  output logic             pll_reset,
  output logic             sys_rst_n,
  output logic             dsp_rst_n,
  output logic             locked_ok,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int unsigned TW = cnt_width(PLL_RST_CYC, LOCK_TIMEOUT_CYC,
                                         LOCK_STABLE_CYC, SEQ_GAP_CYC);
  localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(SEQ_GAP_CYC - 1);
  localparam logic [31:0]   CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

  state_t        state, state_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic          lock_s;
  logic          loss_ev, retry_ev;

  lock_sync u_lock_sync (
    .clk     (clkin),
    .rst_n   (rst_n),
    .async_in(pll_lock),
    .sync_out(lock_s)
  );

  // Next state; the shared dwell counter restarts on every state change.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + TW'(1);
    loss_ev  = 1'b0;
    retry_ev = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == TO_LAST) begin
          state_nx = PLL_RST;
          cnt_nx   = '0;
          retry_ev = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == STB_LAST) begin
          state_nx = REL_SYS;
          cnt_nx   = '0;
        end
      end
      REL_SYS: begin
        if (!lock_s) begin
          state_nx = PLL_RST;
          cnt_nx   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        cnt_nx = '0;
        if (!lock_s) begin
          state_nx = PLL_RST;
          loss_ev  = 1'b1;
        end
      end
      default: begin
        state_nx = PLL_RST;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register with outputs decoded from the next state so they align with it.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      dsp_rst_n <= 1'b0;
      locked_ok <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pll_reset <= (state_nx == PLL_RST);
      sys_rst_n <= (state_nx == REL_SYS) || (state_nx == RUN);
      dsp_rst_n <= (state_nx == RUN);
      locked_ok <= (state_nx == RUN);
    end
  end

  // Status counters; a clear coinciding with an event keeps the event.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      loss_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      if (clr_stat)     loss_cnt <= loss_ev ? CNT_W'(1) : '0;
      else if (loss_ev) loss_cnt <= CNT_W'(sat_inc(32'(loss_cnt), CNT_MAX));

      if (clr_stat)      retry_cnt <= retry_ev ? CNT_W'(1) : '0;
      else if (retry_ev) retry_cnt <= CNT_W'(sat_inc(32'(retry_cnt), CNT_MAX));
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock activity
// checked against a dwell-time reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned P_RST = 4;
  localparam int unsigned P_TO  = 50;
  localparam int unsigned P_STB = 8;
  localparam int unsigned P_GAP = 3;
  localparam int unsigned P_W   = 4;
  localparam int          CMAX  = (1 << P_W) - 1;

  localparam int M_PULSE = 0, M_SEARCH = 1, M_QUAL = 2, M_SYSUP = 3, M_RUN = 4;

  logic           clkin = 1'b0;
  logic           rst_n = 1'b0;
  logic           pll_lock = 1'b0;
  logic           clr_stat = 1'b0;
  logic           pll_reset, sys_rst_n, dsp_rst_n, locked_ok;
  logic [P_W-1:0] loss_cnt, retry_cnt;

  int total = 0;
  int bad   = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYC     (P_RST),
    .LOCK_TIMEOUT_CYC(P_TO),
    .LOCK_STABLE_CYC (P_STB),
    .SEQ_GAP_CYC     (P_GAP),
    .CNT_W           (P_W)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .clr_stat (clr_stat),
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .dsp_rst_n(dsp_rst_n),
    .locked_ok(locked_ok),
    .loss_cnt (loss_cnt),
    .retry_cnt(retry_cnt)
  );

  always #5 clkin = ~clkin;

  // Reference model: mode plus cycles spent in it, applied with the rule set directly.
  logic [1:0] m_sync  = 2'b00;
  int         m_mode  = M_PULSE;
  int         m_dwell = 0;
  int         m_loss  = 0;
  int         m_retry = 0;

  always @(posedge clkin) begin : model
    logic ls;
    bit   ev_loss, ev_retry;
    ev_loss  = 0;
    ev_retry = 0;
    if (!rst_n) begin
      m_sync = 2'b00; m_mode = M_PULSE; m_dwell = 0; m_loss = 0; m_retry = 0;
    end else begin
      ls      = m_sync[1];
      m_sync  = {m_sync[0], pll_lock};
      m_dwell = m_dwell + 1;
      case (m_mode)
        M_PULSE:  if (m_dwell == P_RST) begin m_mode = M_SEARCH; m_dwell = 0; end
        M_SEARCH: if (ls) begin m_mode = M_QUAL; m_dwell = 0; end
                  else if (m_dwell == P_TO) begin m_mode = M_PULSE; m_dwell = 0; ev_retry = 1; end
        M_QUAL:   if (!ls) begin m_mode = M_SEARCH; m_dwell = 0; end
                  else if (m_dwell == P_STB) begin m_mode = M_SYSUP; m_dwell = 0; end
        M_SYSUP:  if (!ls) begin m_mode = M_PULSE; m_dwell = 0; end
                  else if (m_dwell == P_GAP) begin m_mode = M_RUN; m_dwell = 0; end
        default:  if (!ls) begin m_mode = M_PULSE; m_dwell = 0; ev_loss = 1; end
      endcase
      if (clr_stat) m_loss = ev_loss ? 1 : 0;
      else if (ev_loss && m_loss < CMAX) m_loss = m_loss + 1;
      if (clr_stat) m_retry = ev_retry ? 1 : 0;
      else if (ev_retry && m_retry < CMAX) m_retry = m_retry + 1;
    end
  end

  // Stimulus helper: hold lock high until RUN, bounded.
  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (!locked_ok && n < 200) begin
      @(posedge clkin); #1; n++;
    end
    total++;
    if (!locked_ok) begin
      bad++;
      $display("FAIL %s: locked_ok=%0b after %0d cycles, want 1", tag, locked_ok, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock = 1'b0; clr_stat = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    total++;
    if ({pll_reset, sys_rst_n, dsp_rst_n, locked_ok} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_outs: got %b want 1000", {pll_reset, sys_rst_n, dsp_rst_n, locked_ok});
    end
    total++;
    if (loss_cnt !== 0 || retry_cnt !== 0) begin
      bad++;
      $display("FAIL reset_cnts: loss=%0d retry=%0d want 0 0", loss_cnt, retry_cnt);
    end
  endtask

  task automatic test_retry();
    int  n;
    bit  leak;
    leak = 0;
    @(negedge clkin); rst_n = 1'b1;
    for (int pass = 1; pass <= 2; pass++) begin
      n = 0;
      do begin @(posedge clkin); #1; n++; leak |= (sys_rst_n | dsp_rst_n | locked_ok); end
      while (pll_reset && n < 100);
      total++;
      if (n != P_RST) begin bad++; $display("FAIL retry_high%0d: %0d cycles want %0d", pass, n, P_RST); end
      n = 0;
      do begin @(posedge clkin); #1; n++; leak |= (sys_rst_n | dsp_rst_n | locked_ok); end
      while (!pll_reset && n < 200);
      total++;
      if (n != P_TO) begin bad++; $display("FAIL retry_low%0d: %0d cycles want %0d", pass, n, P_TO); end
      total++;
      if (retry_cnt !== P_W'(pass)) begin bad++; $display("FAIL retry_cnt%0d: got %0d want %0d", pass, retry_cnt, pass); end
    end
    total++;
    if (leak) begin bad++; $display("FAIL retry_resets: a reset released during retries, want none"); end
  endtask

  task automatic test_lock_release();
    int n;
    n = 0;
    while (pll_reset && n < 20) begin @(posedge clkin); #1; n++; end
    repeat (9) @(posedge clkin);
    @(negedge clkin); pll_lock = 1'b1;
    @(posedge clkin); #1;
    n = 0;
    do begin @(posedge clkin); #1; n++; end while (!sys_rst_n && n < 40);
    total++;
    if (n != 2 + P_STB) begin bad++; $display("FAIL rel_sys_lat: %0d cycles want %0d", n, 2 + P_STB); end
    n = 0;
    do begin @(posedge clkin); #1; n++; end while (!dsp_rst_n && n < 40);
    total++;
    if (n != P_GAP || !locked_ok) begin
      bad++;
      $display("FAIL rel_dsp_lat: %0d cycles locked_ok=%0b want %0d and 1", n, locked_ok, P_GAP);
    end
    total++;
    if (loss_cnt !== 0) begin bad++; $display("FAIL rel_loss: got %0d want 0", loss_cnt); end
  endtask

  task automatic test_run_loss();
    int n;
    @(negedge clkin); pll_lock = 1'b0;
    @(posedge clkin); #1;
    n = 0;
    do begin @(posedge clkin); #1; n++; end while (sys_rst_n && n < 20);
    total++;
    if (n != 2 || {pll_reset, dsp_rst_n, locked_ok} !== 3'b100) begin
      bad++;
      $display("FAIL loss_lat: %0d cycles pr/dsp/ok=%b want 2 and 100", n, {pll_reset, dsp_rst_n, locked_ok});
    end
    total++;
    if (loss_cnt !== 1) begin bad++; $display("FAIL loss_cnt: got %0d want 1", loss_cnt); end
    @(negedge clkin); pll_lock = 1'b1;
    wait_run("loss_relock");
  endtask

  task automatic test_stable_glitch();
    int n, first;
    @(negedge clkin); pll_lock = 1'b0;
    n = 0;
    while (!pll_reset && n < 20) begin @(posedge clkin); #1; n++; end
    while (pll_reset && n < 40) begin @(posedge clkin); #1; n++; end
    @(negedge clkin); pll_lock = 1'b1;
    first = -1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clkin); #1;
      if (first < 0 && sys_rst_n) first = k;
      @(negedge clkin);
      pll_lock = (k + 1 <= 5) || (k + 1 >= 9);
    end
    total++;
    if (first != 19) begin bad++; $display("FAIL glitch_release: sys_rst_n rose at edge %0d want 19", first); end
    total++;
    if (!locked_ok) begin bad++; $display("FAIL glitch_run: locked_ok=%0b want 1", locked_ok); end
  endtask

  task automatic test_saturation();
    int n;
    @(negedge clkin); clr_stat = 1'b1;
    @(posedge clkin); #1;
    total++;
    if (loss_cnt !== 0 || retry_cnt !== 0) begin
      bad++;
      $display("FAIL clr_alone: loss=%0d retry=%0d want 0 0", loss_cnt, retry_cnt);
    end
    @(negedge clkin); clr_stat = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clkin); pll_lock = 1'b0;
      n = 0;
      while (!pll_reset && n < 20) begin @(posedge clkin); #1; n++; end
      @(negedge clkin); pll_lock = 1'b1;
      wait_run("sat_relock");
    end
    total++;
    if (loss_cnt !== P_W'(CMAX)) begin bad++; $display("FAIL loss_sat: got %0d want %0d", loss_cnt, CMAX); end
    @(negedge clkin); pll_lock = 1'b0;
    @(posedge clkin);
    @(posedge clkin);
    @(negedge clkin); clr_stat = 1'b1;
    @(posedge clkin); #1;
    total++;
    if (loss_cnt !== 1 || pll_reset !== 1'b1) begin
      bad++;
      $display("FAIL clr_with_loss: loss=%0d pll_reset=%0b want 1 1", loss_cnt, pll_reset);
    end
    @(negedge clkin); clr_stat = 1'b0; pll_lock = 1'b1;
    wait_run("clr_relock");
  endtask

  task automatic test_rst_in_run();
    @(negedge clkin); rst_n = 1'b0;
    @(posedge clkin); #1;
    total++;
    if ({pll_reset, sys_rst_n, dsp_rst_n, locked_ok} !== 4'b1000 || loss_cnt !== 0 || retry_cnt !== 0) begin
      bad++;
      $display("FAIL rst_in_run: pr/sys/dsp/ok=%b loss=%0d retry=%0d want 1000 0 0",
               {pll_reset, sys_rst_n, dsp_rst_n, locked_ok}, loss_cnt, retry_cnt);
    end
    @(negedge clkin); rst_n = 1'b1;
  endtask

  task automatic test_random();
    int hold, errs;
    bit saw_run;
    hold = 0; errs = 0; saw_run = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clkin);
      if (hold == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        hold     = pll_lock ? $urandom_range(1, 80) : $urandom_range(1, 70);
      end
      hold--;
      clr_stat = ($urandom_range(0, 63) == 0);
      rst_n    = ($urandom_range(0, 999) != 0);
      @(posedge clkin); #1;
      saw_run |= locked_ok;
      total++;
      if (pll_reset !== (m_mode == M_PULSE) || sys_rst_n !== (m_mode >= M_SYSUP) ||
          dsp_rst_n !== (m_mode == M_RUN) || locked_ok !== (m_mode == M_RUN) ||
          loss_cnt !== P_W'(m_loss) || retry_cnt !== P_W'(m_retry)) begin
        bad++; errs++;
        if (errs <= 10)
          $display("FAIL rand_cycle%0d: pr/sys/dsp/ok=%b loss=%0d retry=%0d want mode %0d loss=%0d retry=%0d",
                   c, {pll_reset, sys_rst_n, dsp_rst_n, locked_ok}, loss_cnt, retry_cnt,
                   m_mode, m_loss, m_retry);
      end
      total++;
      if ((dsp_rst_n && !sys_rst_n) || (pll_reset && (sys_rst_n || dsp_rst_n))) begin
        bad++;
        $display("FAIL rand_invariant%0d: pr/sys/dsp=%b", c, {pll_reset, sys_rst_n, dsp_rst_n});
      end
    end
    total++;
    if (!saw_run) begin bad++; $display("FAIL rand_coverage: RUN never reached, want reached"); end
    clr_stat = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_retry();
    test_lock_release();
    test_run_loss();
    test_stable_glitch();
    test_saturation();
    test_rst_in_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
